// File: rtl/vend_ctrl_multi.sv
// ---------------------------------------------------------------------------
// vend_ctrl_multi
//
// Multi-product vending controller. It accumulates credit from encoded
// coins and vends one of NUM_ITEMS products at runtime prices. It then
// returns the remaining credit as change, one unit per cycle.
//
// Optional feature: define VEND_INVENTORY_EN to add per-item stock counters.
// The counters load STOCK_INIT at reset and are decremented on each dispense.
// The default build has no counters and ties sold_out to 0.
//
// Ports
//   clk           in   system clock, all state on rising edge
//   reset_n       in   asynchronous active-low reset
//   coin_valid    in   one coin presented this cycle
//   coin_code     in   coin value: 0=1, 1=2, 2=5, 3=10 units
//   sel_valid     in   product selection request this cycle
//   sel_idx       in   selected product index
//   cancel        in   abort and refund all credit
//   price_flat    in   item k price at [k*PRICE_W +: PRICE_W]
//   credit        out  current credit
//   busy          out  high in VEND or CHANGE
//   dispense      out  one-cycle pulse: release product
//   dispense_idx  out  product released (valid when dispense=1)
//   change_pulse  out  one unit of change returned this cycle
//   coin_reject   out  one-cycle pulse: presented coin returned
//   err_pulse     out  one-cycle pulse: selection refused
//   sold_out      out  per-item empty flags
//   fsm_state     out  debug view of the controller state
//                      (0=IDLE, 1=CREDIT, 2=VEND, 3=CHANGE)
//
// Handshake: all inputs are single-cycle strobes sampled on the rising edge.
// There is no back-pressure. Inputs that arrive while busy are ignored,
// except coins, which are bounced through coin_reject.
// ---------------------------------------------------------------------------
module vend_ctrl_multi #(
    parameter int CREDIT_W   = 8,
    parameter int NUM_ITEMS  = 4,
    parameter int SEL_W      = 2,
    parameter int PRICE_W    = 8,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 15
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          coin_valid,
    input  logic [1:0]                    coin_code,
    input  logic                          sel_valid,
    input  logic [SEL_W-1:0]              sel_idx,
    input  logic                          cancel,
    input  logic [NUM_ITEMS*PRICE_W-1:0]  price_flat,
    output logic [CREDIT_W-1:0]           credit,
    output logic                          busy,
    output logic                          dispense,
    output logic [SEL_W-1:0]              dispense_idx,
    output logic                          change_pulse,
    output logic                          coin_reject,
    output logic                          err_pulse,
    output logic [NUM_ITEMS-1:0]          sold_out,
    output logic [1:0]                    fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    state_t               state, state_nx;
    logic [CREDIT_W-1:0]  credit_nx;
    logic [SEL_W-1:0]     idx_nx;
    logic                 reject_nx;
    logic                 err_nx;

    logic [3:0]           coin_val;
    logic [CREDIT_W:0]    coin_sum;
    logic [PRICE_W-1:0]   sel_price;
    logic [CREDIT_W-1:0]  price_ext;
    logic                 sel_in_range;
    logic                 sel_sold;
    logic                 sel_ok;

    always_comb begin
        coin_val = 4'd1;
        case (coin_code)
            2'd0: coin_val = 4'd1;
            2'd1: coin_val = 4'd2;
            2'd2: coin_val = 4'd5;
            2'd3: coin_val = 4'd10;
            default: coin_val = 4'd1;
        endcase
    end

    // One extra bit catches overflow so the credit never wraps.
    assign coin_sum = {1'b0, credit} + (CREDIT_W+1)'(coin_val);

    // Price lookup by loop, so out-of-range indices never index past the
    // end of price_flat or the stock array.
    always_comb begin
        sel_price    = '0;
        sel_in_range = 1'b0;
        sel_sold     = 1'b0;
        for (int k = 0; k < NUM_ITEMS; k++) begin
            if (sel_idx == SEL_W'(k)) begin
                sel_price    = price_flat[k*PRICE_W +: PRICE_W];
                sel_in_range = 1'b1;
                sel_sold     = sold_out[k];
            end
        end
    end

    assign price_ext = CREDIT_W'(sel_price);
    assign sel_ok    = sel_in_range && !sel_sold && (credit >= price_ext);

    always_comb begin
        state_nx  = state;
        credit_nx = credit;
        idx_nx    = dispense_idx;
        reject_nx = 1'b0;
        err_nx    = 1'b0;
        case (state)
            IDLE, CREDIT: begin
                // Priority: cancel > selection > coin. A coin that loses to
                // a cancel or a selection is bounced rather than credited.
                // Cancel in IDLE has nothing to refund and is ignored.
                if (cancel && (state == CREDIT)) begin
                    state_nx  = CHANGE;
                    reject_nx = coin_valid;
                end else if (sel_valid) begin
                    reject_nx = coin_valid;
                    if (sel_ok) begin
                        credit_nx = credit - price_ext;
                        idx_nx    = sel_idx;
                        state_nx  = VEND;
                    end else begin
                        err_nx = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_sum[CREDIT_W]) begin
                        reject_nx = 1'b1;
                    end else begin
                        credit_nx = coin_sum[CREDIT_W-1:0];
                        state_nx  = CREDIT;
                    end
                end
            end
            VEND: begin
                reject_nx = coin_valid;
                state_nx  = (credit != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_nx = coin_valid;
                if (credit != '0) begin
                    credit_nx = credit - CREDIT_W'(1);
                end
                if (credit <= CREDIT_W'(1)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            credit       <= '0;
            dispense_idx <= '0;
            coin_reject  <= 1'b0;
            err_pulse    <= 1'b0;
        end else begin
            state        <= state_nx;
            credit       <= credit_nx;
            dispense_idx <= idx_nx;
            coin_reject  <= reject_nx;
            err_pulse    <= err_nx;
        end
    end

    assign busy         = (state == VEND) || (state == CHANGE);
    assign dispense     = (state == VEND);
    assign change_pulse = (state == CHANGE);
    assign fsm_state    = state;

`ifdef VEND_INVENTORY_EN
    logic [STOCK_W-1:0] stock [NUM_ITEMS];

    // Stock is taken in the dispense cycle, so sold_out rises the cycle
    // after the product is released. This is early enough because no new
    // selection can be accepted before the controller leaves VEND.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_ITEMS; k++) begin
                stock[k] <= STOCK_W'(STOCK_INIT);
            end
        end else if (state == VEND) begin
            for (int k = 0; k < NUM_ITEMS; k++) begin
                if ((dispense_idx == SEL_W'(k)) && (stock[k] != '0)) begin
                    stock[k] <= stock[k] - STOCK_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_sold
        assign sold_out[g] = (stock[g] == '0);
    end
`else
    assign sold_out = '0;

    // Stock parameters exist only for the inventory build.
    logic unused_stock_params;
    assign unused_stock_params = ^{STOCK_W[0], STOCK_INIT[0]};
`endif

endmodule

// File: tb/tb_vend_ctrl_multi.sv
module tb_vend_ctrl_multi;

    localparam int N_ITEMS    = 4;
    localparam int CMAX       = 255;
    localparam int STOCK_MAIN = 3;
    localparam int ST_IDLE    = 0;
    localparam int ST_CREDIT  = 1;
    localparam int ST_VEND    = 2;
    localparam int ST_CHANGE  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic        reset_n;
    logic        coin_valid;
    logic [1:0]  coin_code;
    logic        sel_valid;
    logic [1:0]  sel_idx;
    logic        cancel;
    logic [31:0] price_flat;
    logic [7:0]  credit;
    logic        busy, dispense, change_pulse, coin_reject, err_pulse;
    logic [1:0]  dispense_idx;
    logic [3:0]  sold_out;
    logic [1:0]  fsm_state;

    // small instance signals (4-bit credit, 3 items)
    logic        s_reset_n;
    logic        s_coin_valid;
    logic [1:0]  s_coin_code;
    logic        s_sel_valid;
    logic [1:0]  s_sel_idx;
    logic        s_cancel;
    logic [11:0] s_price_flat;
    logic [3:0]  s_credit;
    logic        s_busy, s_dispense, s_change_pulse, s_coin_reject, s_err_pulse;
    logic [1:0]  s_dispense_idx;
    logic [2:0]  s_sold_out;
    logic [1:0]  s_fsm_state;

    vend_ctrl_multi #(
        .CREDIT_W(8), .NUM_ITEMS(4), .SEL_W(2), .PRICE_W(8),
        .STOCK_W(4), .STOCK_INIT(STOCK_MAIN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .coin_valid(coin_valid),
        .coin_code(coin_code), .sel_valid(sel_valid), .sel_idx(sel_idx),
        .cancel(cancel), .price_flat(price_flat), .credit(credit),
        .busy(busy), .dispense(dispense), .dispense_idx(dispense_idx),
        .change_pulse(change_pulse), .coin_reject(coin_reject),
        .err_pulse(err_pulse), .sold_out(sold_out), .fsm_state(fsm_state)
    );

    vend_ctrl_multi #(
        .CREDIT_W(4), .NUM_ITEMS(3), .SEL_W(2), .PRICE_W(4),
        .STOCK_W(4), .STOCK_INIT(1)
    ) dut_small (
        .clk(clk), .reset_n(s_reset_n), .coin_valid(s_coin_valid),
        .coin_code(s_coin_code), .sel_valid(s_sel_valid), .sel_idx(s_sel_idx),
        .cancel(s_cancel), .price_flat(s_price_flat), .credit(s_credit),
        .busy(s_busy), .dispense(s_dispense), .dispense_idx(s_dispense_idx),
        .change_pulse(s_change_pulse), .coin_reject(s_coin_reject),
        .err_pulse(s_err_pulse), .sold_out(s_sold_out), .fsm_state(s_fsm_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Busy periods are held as a queue of scheduled output cycles. An
    // accepted vend schedules one dispense cycle followed by one change cycle
    // per unit of remaining credit. A cancel schedules only change cycles.
    typedef struct {
        bit disp;
        int idx;
    } ev_t;

    ev_t exp_q[$];
    int  m_credit;
    int  m_idx;
    bit  m_rej;
    bit  m_err;
    int  m_stock [N_ITEMS];

    task automatic model_reset();
        exp_q.delete();
        m_credit = 0;
        m_idx    = 0;
        m_rej    = 0;
        m_err    = 0;
        for (int k = 0; k < N_ITEMS; k++) m_stock[k] = STOCK_MAIN;
    endtask

    function automatic int coin_units(input logic [1:0] code);
        int v;
        v = 1;
        case (code)
            2'd0: v = 1;
            2'd1: v = 2;
            2'd2: v = 5;
            default: v = 10;
        endcase
        return v;
    endfunction

    function automatic int m_sold_mask();
        int m;
        m = 0;
`ifdef VEND_INVENTORY_EN
        for (int k = 0; k < N_ITEMS; k++) if (m_stock[k] == 0) m |= (1 << k);
`endif
        return m;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit   rej, err;
        int   price, idx;
        ev_t  ev;
        rej = 0;
        err = 0;
        if (exp_q.size() != 0) begin
            rej = coin_valid;
            ev  = exp_q.pop_front();
            if (ev.disp) begin
                if (m_stock[ev.idx] > 0) m_stock[ev.idx]--;
            end else begin
                m_credit--;
            end
        end else if (cancel && m_credit > 0) begin
            rej = coin_valid;
            for (int i = 0; i < m_credit; i++) exp_q.push_back('{disp: 1'b0, idx: 0});
        end else if (sel_valid) begin
            rej   = coin_valid;
            idx   = int'(sel_idx);
            price = int'(price_flat[idx*8 +: 8]);
            if (idx >= N_ITEMS || m_credit < price || ((m_sold_mask() >> idx) & 1) == 1) begin
                err = 1;
            end else begin
                m_credit -= price;
                m_idx     = idx;
                exp_q.push_back('{disp: 1'b1, idx: idx});
                for (int i = 0; i < m_credit; i++) exp_q.push_back('{disp: 1'b0, idx: 0});
            end
        end else if (coin_valid) begin
            if (m_credit + coin_units(coin_code) > CMAX) rej = 1;
            else m_credit += coin_units(coin_code);
        end
        m_rej = rej;
        m_err = err;
    endtask

    task automatic check_vs_model();
        bit b, d, c;
        b = (exp_q.size() != 0);
        d = b && exp_q[0].disp;
        c = b && !exp_q[0].disp;
        chk("rnd_busy", int'(busy), int'(b));
        chk("rnd_dispense", int'(dispense), int'(d));
        chk("rnd_change", int'(change_pulse), int'(c));
        chk("rnd_credit", int'(credit), m_credit);
        chk("rnd_disp_idx", int'(dispense_idx), m_idx);
        chk("rnd_coin_reject", int'(coin_reject), int'(m_rej));
        chk("rnd_err", int'(err_pulse), int'(m_err));
        chk("rnd_sold_out", int'(sold_out), m_sold_mask());
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit cv, input int cc, input bit sv, input int si, input bit cn);
        @(negedge clk);
        coin_valid = cv;
        coin_code  = 2'(cc);
        sel_valid  = sv;
        sel_idx    = 2'(si);
        cancel     = cn;
        @(posedge clk);
        #1;
    endtask

    task automatic s_drive(input bit cv, input int cc, input bit sv, input int si, input bit cn);
        @(negedge clk);
        s_coin_valid = cv;
        s_coin_code  = 2'(cc);
        s_sel_valid  = sv;
        s_sel_idx    = 2'(si);
        s_cancel     = cn;
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit cv; int cc; bit sv; int si; bit cn;
        int e_credit; int e_state; bit e_disp; int e_idx; bit e_chg; bit e_rej; bit e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit cv, input int cc, input bit sv, input int si, input bit cn,
                           input int ecr, input int est, input bit edi, input int eix,
                           input bit ech, input bit erj, input bit eer);
        vec_t v;
        v.cv = cv; v.cc = cc; v.sv = sv; v.si = si; v.cn = cn;
        v.e_credit = ecr; v.e_state = est; v.e_disp = edi; v.e_idx = eix;
        v.e_chg = ech; v.e_rej = erj; v.e_err = eer;
        vecs.push_back(v);
    endtask

    int pulses;

    initial begin
        reset_n = 0; coin_valid = 0; coin_code = 0; sel_valid = 0; sel_idx = 0; cancel = 0;
        s_reset_n = 0; s_coin_valid = 0; s_coin_code = 0; s_sel_valid = 0; s_sel_idx = 0;
        s_cancel = 0;
        // prices {3,7,12,20} for items 0..3
        price_flat   = {8'd20, 8'd12, 8'd7, 8'd3};
        s_price_flat = {4'd4, 4'd3, 4'd2};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_credit", int'(credit), 0);
        chk("reset_state", int'(fsm_state), ST_IDLE);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pulses", int'({dispense, change_pulse, coin_reject, err_pulse}), 0);
        chk("reset_disp_idx", int'(dispense_idx), 0);
        @(negedge clk);
        reset_n = 1;

        // coins 5,2,2 -> 9, select item 1 (price 7), 2 units change
        add_vec(1, 2, 0, 0, 0,  5, ST_CREDIT, 0, 0, 0, 0, 0);
        add_vec(1, 1, 0, 0, 0,  7, ST_CREDIT, 0, 0, 0, 0, 0);
        add_vec(1, 1, 0, 0, 0,  9, ST_CREDIT, 0, 0, 0, 0, 0);
        add_vec(0, 0, 1, 1, 0,  2, ST_VEND,   1, 1, 0, 0, 0);
        add_vec(0, 0, 0, 0, 0,  2, ST_CHANGE, 0, 0, 1, 0, 0);
        add_vec(0, 0, 0, 0, 0,  1, ST_CHANGE, 0, 0, 1, 0, 0);
        add_vec(0, 0, 0, 0, 0,  0, ST_IDLE,   0, 0, 0, 0, 0);
        // credit 9, item 2 too expensive, then cancel -> 9 units back
        add_vec(1, 2, 0, 0, 0,  5, ST_CREDIT, 0, 0, 0, 0, 0);
        add_vec(1, 1, 0, 0, 0,  7, ST_CREDIT, 0, 0, 0, 0, 0);
        add_vec(1, 1, 0, 0, 0,  9, ST_CREDIT, 0, 0, 0, 0, 0);
        add_vec(0, 0, 1, 2, 0,  9, ST_CREDIT, 0, 0, 0, 0, 1);
        add_vec(0, 0, 0, 0, 1,  9, ST_CHANGE, 0, 0, 1, 0, 0);
        add_vec(1, 3, 0, 0, 0,  8, ST_CHANGE, 0, 0, 1, 1, 0);  // coin while refunding
        for (int c = 7; c >= 1; c--) add_vec(0, 0, 0, 0, 0, c, ST_CHANGE, 0, 0, 1, 0, 0);
        add_vec(0, 0, 0, 0, 0,  0, ST_IDLE,   0, 0, 0, 0, 0);
        // selection and coin in the same cycle: coin bounced, not credited
        add_vec(1, 3, 0, 0, 0, 10, ST_CREDIT, 0, 0, 0, 0, 0);
        add_vec(1, 3, 1, 0, 0,  7, ST_VEND,   1, 0, 0, 1, 0);
        for (int c = 7; c >= 1; c--) add_vec(0, 0, 0, 0, 0, c, ST_CHANGE, 0, 0, 1, 0, 0);
        add_vec(0, 0, 0, 0, 0,  0, ST_IDLE,   0, 0, 0, 0, 0);
        // cancel in IDLE does nothing; selection with no credit refused
        add_vec(0, 0, 0, 0, 1,  0, ST_IDLE,   0, 0, 0, 0, 0);
        add_vec(0, 0, 1, 3, 0,  0, ST_IDLE,   0, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].cv, vecs[i].cc, vecs[i].sv, vecs[i].si, vecs[i].cn);
            chk($sformatf("vec%0d_credit", i), int'(credit), vecs[i].e_credit);
            chk($sformatf("vec%0d_state", i), int'(fsm_state), vecs[i].e_state);
            chk($sformatf("vec%0d_busy", i), int'(busy),
                int'(vecs[i].e_state == ST_VEND || vecs[i].e_state == ST_CHANGE));
            chk($sformatf("vec%0d_dispense", i), int'(dispense), int'(vecs[i].e_disp));
            if (vecs[i].e_disp)
                chk($sformatf("vec%0d_disp_idx", i), int'(dispense_idx), vecs[i].e_idx);
            chk($sformatf("vec%0d_change", i), int'(change_pulse), int'(vecs[i].e_chg));
            chk($sformatf("vec%0d_reject", i), int'(coin_reject), int'(vecs[i].e_rej));
            chk($sformatf("vec%0d_err", i), int'(err_pulse), int'(vecs[i].e_err));
        end

        // reset in the middle of a refund: everything clears at once
        drive(1, 3, 0, 0, 0);
        drive(1, 3, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("midchg_before_credit", int'(credit), 18);
        reset_n = 0;
        #1;
        chk("midchg_rst_credit", int'(credit), 0);
        chk("midchg_rst_change", int'(change_pulse), 0);
        chk("midchg_rst_busy", int'(busy), 0);
        chk("midchg_rst_state", int'(fsm_state), ST_IDLE);
        @(negedge clk);
        reset_n = 1;
        coin_valid = 0; sel_valid = 0; cancel = 0;
        @(posedge clk);
        #1;
        chk("midchg_after_credit", int'(credit), 0);
        model_reset();

        // randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check_vs_model();
            coin_valid = ($urandom_range(0, 99) < 60);
            coin_code  = 2'($urandom_range(0, 3));
            sel_valid  = ($urandom_range(0, 99) < 12);
            sel_idx    = 2'($urandom_range(0, 3));
            cancel     = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 49) == 0) begin
                for (int k = 0; k < N_ITEMS; k++) price_flat[k*8 +: 8] = 8'($urandom_range(0, 40));
            end
            model_step();
        end
        @(negedge clk);
        check_vs_model();
        coin_valid = 0; sel_valid = 0; cancel = 0;

        // small instance: 4-bit credit, 3 items, prices {2,3,4}
        @(negedge clk);
        s_reset_n = 1;
        @(posedge clk);
        #1;
        chk("s_reset_credit", int'(s_credit), 0);
        s_drive(1, 3, 0, 0, 0);
        chk("s_coin10_credit", int'(s_credit), 10);
        chk("s_coin10_state", int'(s_fsm_state), ST_CREDIT);
        s_drive(1, 3, 0, 0, 0);
        chk("s_overflow_reject", int'(s_coin_reject), 1);
        chk("s_overflow_credit", int'(s_credit), 10);
        s_drive(0, 0, 1, 3, 0);
        chk("s_badidx_err", int'(s_err_pulse), 1);
        chk("s_badidx_credit", int'(s_credit), 10);
        chk("s_badidx_state", int'(s_fsm_state), ST_CREDIT);
        s_drive(0, 0, 1, 0, 0);
        chk("s_vend_dispense", int'(s_dispense), 1);
        chk("s_vend_idx", int'(s_dispense_idx), 0);
        chk("s_vend_credit", int'(s_credit), 8);
        pulses = 0;
        s_drive(1, 0, 0, 0, 0);  // coin during the first change cycle's setup
        chk("s_busy_reject", int'(s_coin_reject), 1);
        for (int i = 0; i < 12 && s_busy; i++) begin
            if (s_change_pulse) pulses++;
            s_drive(0, 0, 0, 0, 0);
        end
        chk("s_change_count", pulses, 8);
        chk("s_idle_credit", int'(s_credit), 0);
        chk("s_idle_state", int'(s_fsm_state), ST_IDLE);
`ifdef VEND_INVENTORY_EN
        chk("s_sold_out", int'(s_sold_out), 1);
`else
        chk("s_sold_out", int'(s_sold_out), 0);
`endif
        s_drive(1, 3, 0, 0, 0);
        s_drive(0, 0, 1, 0, 0);
`ifdef VEND_INVENTORY_EN
        chk("s_resel_err", int'(s_err_pulse), 1);
        chk("s_resel_dispense", int'(s_dispense), 0);
`else
        chk("s_resel_err", int'(s_err_pulse), 0);
        chk("s_resel_dispense", int'(s_dispense), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
- Parametrised multi-product vending controller; successor to the single-product coin/dispense FSM.
- Accumulates credit from encoded coins, vends one of NUM_ITEMS products at per-item runtime prices, then returns change one unit per cycle.
- Sits between the coin acceptor front-end and the dispense/change actuator drivers.

Parameters:
CREDIT_W, 8, credit accumulator width in units (max credit 2^CREDIT_W-1)
NUM_ITEMS, 4, number of selectable products
SEL_W, 2, selection index width; NUM_ITEMS must be <= 2^SEL_W
PRICE_W, 8, per-item price width in units; PRICE_W <= CREDIT_W
STOCK_W, 4, per-item stock counter width (INVENTORY_EN only)
STOCK_INIT, 15, stock value loaded at reset (INVENTORY_EN only)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
coin_valid  in  1  one coin presented this cycle
coin_code  in  2  coin value: 0=1, 1=2, 2=5, 3=10 units
sel_valid  in  1  product selection request this cycle
sel_idx  in  SEL_W  selected product index
cancel  in  1  abort and refund all credit
price_flat  in  NUM_ITEMS*PRICE_W  item k price at bits [k*PRICE_W +: PRICE_W]; sampled only on acceptance of a selection
credit  out  CREDIT_W  current credit
busy  out  1  high in VEND or CHANGE
dispense  out  1  one-cycle pulse: release product
dispense_idx  out  SEL_W  product released; valid when dispense=1
change_pulse  out  1  one unit of change returned this cycle
coin_reject  out  1  one-cycle pulse: presented coin returned, not credited
err_pulse  out  1  one-cycle pulse: selection refused
sold_out  out  NUM_ITEMS  per-item empty flags (all 0 without INVENTORY_EN)

Behaviour:
- Reset (async assert, sync release): state=IDLE, credit=0, all pulse outputs 0, dispense_idx=0, busy=0; stock counters=STOCK_INIT when enabled.
- States: IDLE (credit=0), CREDIT (credit>0), VEND, CHANGE. busy=1 in VEND and CHANGE only.
- Per-cycle priority in IDLE/CREDIT: cancel > sel_valid > coin_valid. A coin arriving in the same cycle as an accepted cancel or selection is not credited: coin_reject=1 next cycle.
- Coin accept: credit <= credit + value; IDLE->CREDIT. If sum > 2^CREDIT_W-1: credit unchanged, coin_reject pulses. No wrap.
- Selection: refused (err_pulse, state/credit unchanged) if sel_idx >= NUM_ITEMS, credit < price[sel_idx], or the item is sold out. Otherwise credit <= credit - price; dispense_idx <= sel_idx; ->VEND. Price 0 is legal (free vend; credit may be 0).
- VEND: dispense=1 for exactly this one cycle; next state CHANGE if credit>0, else IDLE. Latency from accepted sel_valid to dispense: 1 cycle.
- CHANGE: change_pulse=1 and credit decrements by 1 each cycle; after the cycle that takes credit to 0, ->IDLE. N units of change take N cycles.
- cancel in CREDIT: ->CHANGE directly, no dispense. cancel in IDLE: no effect.
- While busy: sel_valid and cancel ignored; coin_valid produces coin_reject.
- Reset mid-vend or mid-change: credit is lost and outputs clear immediately. Documented system behaviour.

Optional Feature:
- Macro VEND_INVENTORY_EN.
- Defined: per-item STOCK_W counters, decremented on each dispense, saturating at 0; sold_out[k]=1 when stock[k]==0; selecting a sold-out item gives err_pulse.
- Undefined: no counters; sold_out tied to 0; stock never limits a vend.

Test Plan:
- Reset then coins 5,2,2 (codes 2,1,1) -> credit=9, state CREDIT, no reject.
- Prices {3,7,12,20}, credit 9, select 1 -> next cycle dispense=1, dispense_idx=1; then change_pulse for exactly 2 cycles; credit=0; IDLE.
- Credit 9, select 2 (price 12) -> err_pulse, credit stays 9. Then cancel -> 9 change pulses, no dispense.
- CREDIT_W=4, credit 10, insert 10 -> coin_reject, credit stays 10. Coin during CHANGE -> coin_reject, change sequence continues unaltered.
- Same-cycle sel_valid (valid select) and coin_valid -> dispense follows, coin_reject pulses, coin value not in credit. sel_idx=3 with NUM_ITEMS=3 -> err_pulse.
- VEND_INVENTORY_EN, STOCK_INIT=1: vend item 0 -> sold_out[0]=1; second selection of item 0 -> err_pulse. reset_n low mid-CHANGE -> credit=0, change_pulse=0 immediately.
